time_keeper_multi: RTL
======================

TIME_KEEPER_MULTI -- requirements
Module: time_keeper_multi

Interface
REQ-001 SHALL have parameter BASE, default 0, settings-bus base address.
REQ-002 SHALL have parameter TW, default 64, tick counter width; legal range 33..64.
REQ-003 SHALL have parameter NSRC, default 2, number of PPS inputs; legal range 1..8.
REQ-004 SHALL have parameter PPS_TIMEOUT, default 120000000, cycles without selected edge before loss is flagged.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset rst, synchronous, active-high.
REQ-007 set_stb  in  1  settings write strobe.
REQ-008 set_addr  in  8  settings address.
REQ-009 set_data  in  32  settings data.
REQ-010 pps_in  in  NSRC  asynchronous PPS inputs.
REQ-011 time_now  out  TW  current time, one register stage after tick counter.
REQ-012 time_pps  out  TW  time_now captured at last selected PPS edge.
REQ-013 pps_int  out  1  one-cycle pulse per selected PPS edge.
REQ-014 pps_lost  out  1  high while selected PPS is absent longer than PPS_TIMEOUT.
REQ-015 pps_count  out  16  count of selected PPS edges, wraps modulo 2^16.
REQ-016 armed  out  1  high while a preset load is pending.

Function
REQ-017 Registers SHALL be BASE+0 TICKS_HI, BASE+1 TICKS_LO, BASE+2 CTRL; other addresses ignored.
REQ-018 CTRL SHALL decode [2:0] source select, [8] polarity (1 = rising edge active), [9] mode (0 = load on next PPS, 1 = load immediately); reset value 0x100.
REQ-019 Source select >= NSRC SHALL select no source: pps_int never asserts, watchdog keeps counting.
REQ-020 Each pps_in bit SHALL pass a 2-flop synchroniser, then an edge detector per polarity; pps_int asserts for exactly one cycle, 3 cycles after the selected input is first sampled active.
REQ-021 Changing source or polarity SHALL NOT produce a spurious pps_int in the cycle of change or the following cycle.
REQ-022 Preset SHALL be {TICKS_HI,TICKS_LO}[TW-1:0]; writing TICKS_HI arms; TICKS_LO must be written first.
REQ-023 FSM states SHALL be IDLE and ARMED; IDLE->ARMED on TICKS_HI write; ARMED->IDLE on load; armed = (state == ARMED).
REQ-024 Mode 0: in ARMED, the cycle with pps_int = 1 SHALL load the tick counter with the preset instead of incrementing.
REQ-025 Mode 1: the cycle after the TICKS_HI write SHALL load the preset without waiting for PPS.
REQ-026 TICKS_HI write coincident with pps_int SHALL arm only; the load uses the next edge (mode 0).
REQ-027 Otherwise the tick counter SHALL increment by 1 per cycle, wrapping from 2^TW-1 to 0.
REQ-028 time_now SHALL equal the tick counter delayed by one cycle; a load at edge k is visible on time_now after edge k+1.
REQ-029 time_pps SHALL capture time_now in the pps_int cycle, before any load in that cycle takes effect.
REQ-030 Watchdog counter SHALL reset to 0 on pps_int and saturate at PPS_TIMEOUT; pps_lost = (counter == PPS_TIMEOUT).
REQ-031 pps_lost SHALL deassert in the cycle after pps_int.
REQ-032 Changing source select SHALL reset the watchdog counter to 0.

Reset
REQ-033 On rst: tick counter, time_now, time_pps, pps_count, watchdog = 0; pps_lost = 0; pps_int = 0; FSM = IDLE; synchronisers cleared; CTRL = 0x100; TICKS_HI/LO = 0.
REQ-034 rst asserted while ARMED SHALL discard the pending load.

Structure
REQ-035 Package time_keeper_pkg SHALL hold register offsets, CTRL bit positions, and the FSM state enum.
REQ-036 Sub-module pps_edge_det (synchroniser + polarity edge detect) SHALL be instantiated once per source.

Verification
REQ-037 Reset, no PPS, 10 cycles -> time_now = 9 at cycle 10, pps_int never high.
REQ-038 Write LO=0x10, HI=0 mode 0, rising edge on pps_in[0] -> armed = 1 until pps_int; time_now = 0x10 one cycle after load, then 0x11.
REQ-039 Mode 1, LO=0xFFFFFFFF, HI=0xFFFFFFFF, TW=64 -> load next cycle; counter wraps to 0 two cycles later.
REQ-040 TICKS_HI write coincident with pps_int -> no load on that edge; load on following edge; pps_count increments on both edges.
REQ-041 PPS_TIMEOUT=100, stop PPS -> pps_lost high 100 cycles after last pps_int; next edge clears it one cycle after pps_int.
REQ-042 Select source 3 with NSRC=2 while toggling all inputs -> no pps_int, pps_lost asserts after PPS_TIMEOUT.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared definitions for the multi-source PPS time keeper: settings register
// offsets, CTRL field positions and reset value, and the preset FSM states.
package time_keeper_pkg;

    localparam int REG_TICKS_HI = 0;
    localparam int REG_TICKS_LO = 1;
    localparam int REG_CTRL     = 2;

    localparam int CTRL_SRC_LSB  = 0;
    localparam int CTRL_SRC_MSB  = 2;
    localparam int CTRL_POL_BIT  = 8;
    localparam int CTRL_MODE_BIT = 9;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0100;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/pps_edge_det.sv
// Brings one asynchronous PPS input into the clock domain and produces a
// registered one-cycle pulse on its active edge (rising when polarity = 1).
module pps_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pps,
    input  logic polarity,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two-flop synchroniser, a history flop, and a registered edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= pps;
            sync2 <= sync1;
            prev  <= sync2;
            pulse <= polarity ? (sync2 & ~prev) : (~sync2 & prev);
        end
    end

endmodule

// File: rtl/time_keeper_multi.sv
// Free-running tick counter disciplined by one of several PPS inputs, with a
// settings bus for presetting time and selecting source, polarity and load mode.
module time_keeper_multi
    import time_keeper_pkg::*;
#(
    parameter int BASE        = 0,
    parameter int TW          = 64,
    parameter int NSRC        = 2,
    parameter int PPS_TIMEOUT = 120000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_stb,
    input  logic [7:0]      set_addr,
    input  logic [31:0]     set_data,
    input  logic [NSRC-1:0] pps_in,
    output logic [TW-1:0]   time_now,
    output logic [TW-1:0]   time_pps,
    output logic            pps_int,
    output logic            pps_lost,
    output logic [15:0]     pps_count,
    output logic            armed
);

    localparam int WDW = (PPS_TIMEOUT < 2) ? 1 : $clog2(PPS_TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(PPS_TIMEOUT);

    localparam logic [7:0] ADDR_HI   = 8'(BASE + REG_TICKS_HI);
    localparam logic [7:0] ADDR_LO   = 8'(BASE + REG_TICKS_LO);
    localparam logic [7:0] ADDR_CTRL = 8'(BASE + REG_CTRL);

    logic [31:0]    ticks_lo;
    logic [TW-33:0] ticks_hi;
    logic [2:0]     src_sel;
    logic           polarity;
    logic           mode;
    logic [NSRC-1:0] edges;
    logic           sel_edge;
    logic [1:0]     quiet;
    logic [TW-1:0]  tick;
    logic [WDW-1:0] watchdog;
    logic           load;
    state_t         state;
    state_t         state_next;

    logic wr_hi;
    logic wr_lo;
    logic wr_ctrl;
    logic src_change;
    logic ctrl_change;

    assign wr_hi   = set_stb && (set_addr == ADDR_HI);
    assign wr_lo   = set_stb && (set_addr == ADDR_LO);
    assign wr_ctrl = set_stb && (set_addr == ADDR_CTRL);

    assign src_change  = wr_ctrl && (set_data[CTRL_SRC_MSB:CTRL_SRC_LSB] != src_sel);
    assign ctrl_change = src_change || (wr_ctrl && (set_data[CTRL_POL_BIT] != polarity));

    assign armed    = (state == ARMED);
    assign pps_lost = (watchdog == WD_MAX);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        pps_edge_det u_det (
            .clk      (clk),
            .rst      (rst),
            .pps      (pps_in[i]),
            .polarity (polarity),
            .pulse    (edges[i])
        );
    end

    // Settings registers: preset halves and CTRL fields
    always_ff @(posedge clk) begin
        if (rst) begin
            ticks_lo <= '0;
            ticks_hi <= '0;
            src_sel  <= CTRL_RESET[CTRL_SRC_MSB:CTRL_SRC_LSB];
            polarity <= CTRL_RESET[CTRL_POL_BIT];
            mode     <= CTRL_RESET[CTRL_MODE_BIT];
        end else begin
            if (wr_lo) ticks_lo <= set_data;
            if (wr_hi) ticks_hi <= set_data[TW-33:0];
            if (wr_ctrl) begin
                src_sel  <= set_data[CTRL_SRC_MSB:CTRL_SRC_LSB];
                polarity <= set_data[CTRL_POL_BIT];
                mode     <= set_data[CTRL_MODE_BIT];
            end
        end
    end

    // Pick the selected source's edge; out-of-range selects give nothing
    always_comb begin
        sel_edge = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_sel == 3'(i)) sel_edge = edges[i];
        end
    end

    // PPS pulse, edge counter, and a two-cycle blanking window after a source/polarity change
    always_ff @(posedge clk) begin
        if (rst) begin
            pps_int   <= 1'b0;
            quiet     <= 2'b00;
            pps_count <= '0;
        end else begin
            pps_int <= sel_edge & ~quiet[0];
            quiet   <= ctrl_change ? 2'b11 : {1'b0, quiet[1]};
            if (pps_int) pps_count <= pps_count + 16'd1;
        end
    end

    // Preset FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Arm on a TICKS_HI write; load on PPS (mode 0) or next cycle (mode 1); a rewrite re-arms instead of loading
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (wr_hi) state_next = ARMED;
            end
            ARMED: begin
                if (!wr_hi && (mode || pps_int)) begin
                    load       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Tick counter, its one-cycle delayed copy, and the PPS time capture
    always_ff @(posedge clk) begin
        if (rst) begin
            tick     <= '0;
            time_now <= '0;
            time_pps <= '0;
        end else begin
            tick     <= load ? {ticks_hi, ticks_lo} : tick + TW'(1);
            time_now <= tick;
            if (pps_int) time_pps <= time_now;
        end
    end

    // Loss-of-PPS watchdog: cleared by a PPS or a source change, saturates at the timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            watchdog <= '0;
        end else if (pps_int || src_change) begin
            watchdog <= '0;
        end else if (watchdog != WD_MAX) begin
            watchdog <= watchdog + WDW'(1);
        end
    end

endmodule
